// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-state data memory.
package dmem_pkg;

  localparam int LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extract/extend for loads.
// Also flags accesses that do not sit on their natural boundary.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic        is_byte;
  logic        is_half;
  logic [31:0] shifted;

  assign is_byte = size == SZ_BYTE;
  assign is_half = size == SZ_HALF;
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    be       = 4'b1111;
    wlanes   = wdata;
    rdata    = shifted;
    misalign = 1'b0;
    unique case (1'b1)
      is_byte: begin
        be     = 4'b0001 << lane;
        wlanes = {4{wdata[7:0]}};
        rdata  = {{24{~zext & shifted[7]}}, shifted[7:0]};
      end
      is_half: begin
        misalign = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{wdata[15:0]}};
        rdata    = {{16{~zext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        // word and the reserved size code behave identically
        misalign = |lane;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ws.sv
// Byte-addressed data memory with a wait-state request/ready FSM.
// DATA_MEMORY_BOUNDS_CHECK_EN: treat addresses past the array as errors.
module data_memory_ws
  import dmem_pkg::*;
#(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH       = 256,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_in,
  input  logic              write_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  input  logic [31:0]       address_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready_out,
  output logic              misalign_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 2);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t      state;
  logic [CW-1:0] cnt;

  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic        idle;
  logic        wr_s;
  logic        uns_s;
  logic [1:0]  size_s;
  logic [31:0] addr_s;
  logic [31:0] data_s;

  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [31:0]   ld_data;
  logic          mis_a;
  logic          err;
  logic          commit;

  // with zero wait states the commit edge is the accept edge itself
  assign idle   = state == IDLE;
  assign wr_s   = idle ? write_in    : wr_q;
  assign uns_s  = idle ? unsigned_in : uns_q;
  assign size_s = idle ? size_in     : size_q;
  assign addr_s = idle ? address_in  : addr_q;
  assign data_s = idle ? data_in     : data_q;

  assign idx = addr_s[AW+1:2];

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
  assign err = mis_a | ({1'b0, addr_s} >= LIMIT);
`else
  logic unused_hi;
  assign unused_hi = ^addr_s[31:AW+2];
  assign err = mis_a;
`endif

  assign commit = ~reset & (
    (idle & req_in & (WAIT_CYCLES == 0)) |
    ((state == WAIT) & (cnt == CW'(1))));

  dmem_lane_align u_align (
    .size     (size_s),
    .zext     (uns_s),
    .lane     (addr_s[1:0]),
    .wdata    (data_s),
    .rword    (mem[idx]),
    .be       (be),
    .wlanes   (wlanes),
    .rdata    (ld_data),
    .misalign (mis_a)
  );

  always_ff @(posedge clk) begin
    if (commit && wr_s && !err) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wlanes[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (idle && req_in) begin
      wr_q   <= write_in;
      uns_q  <= unsigned_in;
      size_q <= size_in;
      addr_q <= address_in;
      data_q <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      data_out     <= '0;
      ready_out    <= 1'b0;
      misalign_out <= 1'b0;
    end else begin
      ready_out    <= commit;
      misalign_out <= commit & err;
      if (commit && !wr_s && !err) data_out <= ld_data;
      unique case (state)
        IDLE: begin
          if (req_in) begin
            cnt   <= CW'(WAIT_CYCLES);
            state <= (WAIT_CYCLES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// Scoreboard bench for data_memory_ws at 0, 1 and 3 wait states.
module tb_data_memory_ws;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic        wr;
  logic [1:0]  sz;
  logic        un;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        mis  [3];

  int wv [3] = '{1, 0, 3};

  typedef struct {
    logic [31:0] data;
    logic        m;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] hold [3];
  int          n_tot = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  data_memory_ws #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .req_in(req[0]), .write_in(wr),
    .size_in(sz), .unsigned_in(un), .address_in(addr), .data_in(wd),
    .data_out(dout[0]), .ready_out(rdy[0]), .misalign_out(mis[0])
  );

  data_memory_ws #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_in(req[1]), .write_in(wr),
    .size_in(sz), .unsigned_in(un), .address_in(addr), .data_in(wd),
    .data_out(dout[1]), .ready_out(rdy[1]), .misalign_out(mis[1])
  );

  data_memory_ws #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .req_in(req[2]), .write_in(wr),
    .size_in(sz), .unsigned_in(un), .address_in(addr), .data_in(wd),
    .data_out(dout[2]), .ready_out(rdy[2]), .misalign_out(mis[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic acc(input int d, input logic w, input logic [1:0] s,
                     input logic u, input logic [31:0] a,
                     input logic [31:0] dat, input logic [31:0] ld,
                     input logic m, input string tag);
    exp_t e;
    int   n;
    @(negedge clk);
    wr = w; sz = s; un = u; addr = a; wd = dat; req[d] = 1'b1;
    e.data = (w || m) ? hold[d] : ld;
    e.m    = m;
    sbq.push_back(e);
    @(negedge clk);
    req[d] = 1'b0;
    wr = ~w; sz = ~s; un = ~u; addr = ~a; wd = ~dat;
    n = 0;
    while (rdy[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, wv[d]);
    e = sbq.pop_front();
    chk({tag, "_dat"}, dout[d], e.data);
    chk({tag, "_mis"}, {31'b0, mis[d]}, {31'b0, e.m});
    hold[d] = e.data;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, rdy[d]}, 32'd0);
  endtask

  task automatic held(input int d, input int cycles);
    @(negedge clk);
    wr = 1'b0; sz = SZ_WORD; un = 1'b0; addr = 32'h8; req[d] = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk($sformatf("held%0d_%0d", d, i), {31'b0, rdy[d]},
          {31'b0, (i % (wv[d] + 2)) == wv[d]});
    end
    req[d] = 1'b0;
    hold[d] = 32'h01020304;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    req = '0; wr = 0; sz = '0; un = 0; addr = '0; wd = '0;
    reset = 1'b1;
    hold = '{default: 32'h0};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_dout%0d", d), dout[d], 32'h0);
      chk($sformatf("rst_rdy%0d", d), {31'b0, rdy[d]}, 32'h0);
      chk($sformatf("rst_mis%0d", d), {31'b0, mis[d]}, 32'h0);
    end
    reset = 1'b0;

    acc(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 0, "st_w");
    acc(0, 0, SZ_WORD, 0, 32'h10, 0, 32'hDEADBEEF, 0, "ld_w");
    acc(0, 1, SZ_BYTE, 0, 32'h11, 32'hFFFFFF7A, 0, 0, "st_b");
    acc(0, 0, SZ_WORD, 1, 32'h10, 0, 32'hDEAD7AEF, 0, "ld_w2");
    acc(0, 0, SZ_BYTE, 0, 32'h13, 0, 32'hFFFFFFDE, 0, "ld_bs");
    acc(0, 0, SZ_HALF, 1, 32'h12, 0, 32'h0000DEAD, 0, "ld_hu");
    acc(0, 0, SZ_HALF, 0, 32'h12, 0, 32'hFFFFDEAD, 0, "ld_hs");
    acc(0, 0, SZ_BYTE, 1, 32'h11, 0, 32'h0000007A, 0, "ld_bu");
    acc(0, 1, SZ_HALF, 0, 32'h12, 32'hAAAA5555, 0, 0, "st_h");
    acc(0, 0, 2'b11, 0, 32'h10, 0, 32'h55557AEF, 0, "ld_rsv");

    acc(0, 1, SZ_WORD, 0, 32'h20, 32'h0BADF00D, 0, 0, "st_20");
    acc(0, 1, SZ_WORD, 0, 32'h22, 32'h12345678, 0, 1, "st_mis");
    acc(0, 0, SZ_WORD, 0, 32'h20, 0, 32'h0BADF00D, 0, "ld_20");
    acc(0, 0, SZ_HALF, 0, 32'h11, 0, 0, 1, "ld_mis");

    acc(0, 1, SZ_WORD, 0, 32'h0, 32'h55667788, 0, 0, "st_0");
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    acc(0, 1, SZ_WORD, 0, 32'h400, 32'h11223344, 0, 1, "st_oob");
    acc(0, 0, SZ_WORD, 0, 32'h0, 0, 32'h55667788, 0, "ld_0");
`else
    acc(0, 1, SZ_WORD, 0, 32'h400, 32'h11223344, 0, 0, "st_wrap");
    acc(0, 0, SZ_WORD, 0, 32'h0, 0, 32'h11223344, 0, "ld_0");
`endif

    acc(1, 1, SZ_WORD, 0, 32'h8, 32'h01020304, 0, 0, "w0_st");
    acc(1, 0, SZ_WORD, 0, 32'h8, 0, 32'h01020304, 0, "w0_ld");
    acc(2, 1, SZ_WORD, 0, 32'h8, 32'h01020304, 0, 0, "w3_st");
    acc(2, 0, SZ_WORD, 0, 32'h8, 0, 32'h01020304, 0, "w3_ld");

    held(1, 4);
    held(2, 10);

    acc(0, 1, SZ_WORD, 0, 32'h40, 32'h11111111, 0, 0, "st_40");
    acc(0, 0, SZ_WORD, 0, 32'h40, 0, 32'h11111111, 0, "ld_40");
    @(negedge clk);
    wr = 1'b1; sz = SZ_WORD; un = 1'b0; addr = 32'h40; wd = 32'h99999999;
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rs_dout", dout[0], 32'h0);
    chk("rs_rdy", {31'b0, rdy[0]}, 32'h0);
    chk("rs_mis", {31'b0, mis[0]}, 32'h0);
    hold = '{default: 32'h0};
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rdy[0];
    end
    chk("rs_noready", {31'b0, seen}, 32'h0);
    acc(0, 0, SZ_WORD, 0, 32'h40, 0, 32'h11111111, 0, "rs_ld");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
